mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares a single RAM port between two cores. Each core presents one instruction-read channel and one data read/write channel.
- Sits between the per-core request units / caches and the RAM model.
- Selects one requester, drives the RAM strobes, waits for RAM completion, then returns data and releases that requester.
- Round-robin between cores; within a core, data access has priority over instruction fetch.

Parameters:
- WORD_W, 32, width of addresses and data words.
- TIMEOUT, 255, max cycles a grant may wait for RAM completion before abort (8-bit counter, legal range 1..255).

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous, active-low reset.
- iREN  input  2  instruction read request, bit c = core c.
- dREN  input  2  data read request per core.
- dWEN  input  2  data write request per core.
- iaddr  input  2xWORD_W  instruction address per core.
- daddr  input  2xWORD_W  data address per core.
- dstore  input  2xWORD_W  write data per core.
- iwait  output  2  high while core's instruction request is pending.
- dwait  output  2  high while core's data request is pending.
- iload  output  2xWORD_W  instruction read data per core.
- dload  output  2xWORD_W  data read data per core.
- ramREN  output  1  RAM read strobe.
- ramWEN  output  1  RAM write strobe.
- ramaddr  output  WORD_W  RAM address.
- ramstore  output  WORD_W  RAM write data.
- ramload  input  WORD_W  RAM read data.
- ramstate  input  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- timeout  output  2  one-cycle pulse per core when its grant was aborted by timeout.

Behaviour:
- States: IDLE, GRANT.
- Registered state: state, gcore (granted core), gdata (1 = data channel), rr (core with priority), tcnt (8-bit).
- Reset (async): state=IDLE, rr=0, gcore=0, gdata=0, tcnt=0, timeout=0.
- Combinational outputs: ramREN=ramWEN=0; ramaddr=ramstore=0; iwait/dwait follow request rules below; iload/dload=0 except as noted.
- Request pending for a channel: iREN[c], or (dREN[c] | dWEN[c]).
- IDLE selection:
  - Core = rr if rr has any pending request, else the other core if it has one.
  - Channel within core = data if dREN|dWEN, else instruction.
  - With any request: next edge -> GRANT, latch gcore/gdata, tcnt=0. With none: stay IDLE.
  - RAM strobes are 0 in IDLE; minimum 1 idle cycle between grants.
- GRANT drive (combinational from gcore/gdata):
  - Data channel: ramaddr=daddr[gcore], ramstore=dstore[gcore], ramWEN=dWEN[gcore], ramREN=dREN[gcore] & ~dWEN[gcore]. Write wins if both set.
  - Instruction channel: ramaddr=iaddr[gcore], ramREN=1.
- Completion (ramstate==ACCESS in GRANT):
  - Granted wait bit is 0 that same cycle; iload/dload[gcore]=ramload that cycle.
  - Next edge: IDLE, rr<=~gcore.
- ERROR in GRANT: wait stays 1, no data returned; next edge IDLE, rr<=~gcore. The request is retried on a later arbitration.
- FREE/BUSY in GRANT: tcnt increments.
  - tcnt==TIMEOUT-1 with no ACCESS: next edge IDLE, rr<=~gcore, timeout[gcore] pulses 1 cycle. The requester's wait stays high.
- Wait bits: iwait[c]=iREN[c] and dwait[c]=dREN[c]|dWEN[c], except for the completing channel in its ACCESS cycle.
- Requester drops its request mid-GRANT: strobes fall combinationally; next edge IDLE, no rr change, no timeout.
- Simultaneous ACCESS and request drop: treated as completion.
- Requesters hold address, data and strobes stable until their wait bit is low.
- Latency: request in IDLE cycle N; strobes asserted cycle N+1; earliest completion cycle N+1 if RAM returns ACCESS immediately.

Test Plan:
- Core0 iREN, iaddr=0x40, RAM ACCESS after 2 BUSY cycles with ramload=0x8C010004 -> ramREN=1, ramaddr=0x40 for 3 cycles; iwait[0]=0 and iload[0]=0x8C010004 in ACCESS cycle; rr becomes 1.
- Core1 dWEN, daddr=0x100, dstore=0xDEADBEEF, simultaneous with core1 iREN -> data granted first (ramWEN=1, ramstore=0xDEADBEEF); instruction served after core0 gets its turn.
- Both cores continuously requesting instruction fetch, RAM always ACCESS -> grants alternate 0,1,0,1 with 1 IDLE cycle between; no core starves.
- dREN and dWEN both set on core0 -> ramWEN=1, ramREN=0.
- TIMEOUT=4, RAM stuck BUSY on core1 grant -> after 4 GRANT cycles timeout[1] pulses 1 cycle, state IDLE, dwait[1] still 1, next grant goes to core0 if requesting.
- nRST asserted mid-GRANT -> ramREN/ramWEN drop immediately; after release state IDLE, rr=0, core0 wins a simultaneous request.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-core arbiter sharing one RAM port: round-robin between cores, data before instruction
// within a core, with an abort timeout on grants the RAM never completes.
module mem_arbiter #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [1:0]             iREN,
  input  logic [1:0]             dREN,
  input  logic [1:0]             dWEN,
  input  logic [1:0][WORD_W-1:0] iaddr,
  input  logic [1:0][WORD_W-1:0] daddr,
  input  logic [1:0][WORD_W-1:0] dstore,
  output logic [1:0]             iwait,
  output logic [1:0]             dwait,
  output logic [1:0][WORD_W-1:0] iload,
  output logic [1:0][WORD_W-1:0] dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic [1:0]             ramstate,
  output logic [1:0]             timeout
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [1:0] RamAccess = 2'd2;
  localparam logic [1:0] RamError  = 2'd3;
  localparam logic [7:0] TcntLast  = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       gcore_q, gcore_d;
  logic       gdata_q, gdata_d;
  logic       rr_q, rr_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic [1:0] timeout_q, timeout_d;

  logic [1:0] pend_d;
  logic [1:0] pend_any;
  logic       sel_core;
  logic       still_req;

  assign pend_d   = dREN | dWEN;
  assign pend_any = iREN | pend_d;
  assign timeout  = timeout_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= StIdle;
      gcore_q   <= 1'b0;
      gdata_q   <= 1'b0;
      rr_q      <= 1'b0;
      tcnt_q    <= 8'd0;
      timeout_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      gcore_q   <= gcore_d;
      gdata_q   <= gdata_d;
      rr_q      <= rr_d;
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gcore_d   = gcore_q;
    gdata_d   = gdata_q;
    rr_d      = rr_q;
    tcnt_d    = tcnt_q;
    timeout_d = 2'b00;
    sel_core  = rr_q;
    still_req = 1'b0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    iwait     = iREN;
    dwait     = pend_d;
    iload     = '0;
    dload     = '0;

    unique case (state_q)
      StIdle: begin
        if (|pend_any) begin
          sel_core = pend_any[rr_q] ? rr_q : ~rr_q;
          state_d  = StGrant;
          gcore_d  = sel_core;
          gdata_d  = pend_d[sel_core];
          tcnt_d   = 8'd0;
        end
      end
      StGrant: begin
        // Strobes track the live request so a dropped request releases the RAM at once.
        if (gdata_q) begin
          ramaddr   = daddr[gcore_q];
          ramstore  = dstore[gcore_q];
          ramWEN    = dWEN[gcore_q];
          ramREN    = dREN[gcore_q] & ~dWEN[gcore_q];
          still_req = pend_d[gcore_q];
        end else begin
          ramaddr   = iaddr[gcore_q];
          ramREN    = iREN[gcore_q];
          still_req = iREN[gcore_q];
        end

        if (ramstate == RamAccess) begin
          if (gdata_q) begin
            dwait[gcore_q] = 1'b0;
            dload[gcore_q] = ramload;
          end else begin
            iwait[gcore_q] = 1'b0;
            iload[gcore_q] = ramload;
          end
          state_d = StIdle;
          rr_d    = ~gcore_q;
        end else if (!still_req) begin
          state_d = StIdle;
        end else if (ramstate == RamError) begin
          state_d = StIdle;
          rr_d    = ~gcore_q;
        end else if (tcnt_q == TcntLast) begin
          state_d            = StIdle;
          rr_d               = ~gcore_q;
          timeout_d[gcore_q] = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, all outputs compared every
// cycle against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int unsigned W  = 32;
  localparam int unsigned TO = 4;

  logic              CLK, nRST;
  logic [1:0]        iREN, dREN, dWEN;
  logic [1:0][W-1:0] iaddr, daddr, dstore;
  logic [1:0]        iwait, dwait;
  logic [1:0][W-1:0] iload, dload;
  logic              ramREN, ramWEN;
  logic [W-1:0]      ramaddr, ramstore, ramload;
  logic [1:0]        ramstate;
  logic [1:0]        timeout;

  mem_arbiter #(.WORD_W(W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait),
    .iload(iload), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate), .timeout(timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: is a transfer outstanding, whose, for how long, and who has priority.
  bit         m_busy, m_core, m_data, m_prio;
  int         m_waited;
  logic [1:0] m_to;

  task automatic settle();
    logic              e_ren, e_wen, still, pick;
    logic [W-1:0]      e_addr, e_store;
    logic [1:0]        e_iwait, e_dwait, nxt_to;
    logic [1:0][W-1:0] e_iload, e_dload;
    #1;
    if (!nRST) begin
      m_busy = 0; m_prio = 0; m_to = 2'b00; m_core = 0; m_data = 0; m_waited = 0;
    end
    e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0; e_iload = '0; e_dload = '0;
    e_iwait = iREN; e_dwait = dREN | dWEN; nxt_to = 2'b00;
    if (m_busy) begin
      if (m_data) begin
        e_addr  = daddr[m_core];
        e_store = dstore[m_core];
        e_wen   = dWEN[m_core];
        e_ren   = dREN[m_core] && !dWEN[m_core];
        still   = dREN[m_core] || dWEN[m_core];
      end else begin
        e_addr = iaddr[m_core];
        e_ren  = iREN[m_core];
        still  = iREN[m_core];
      end
    end
    check_eq("ramREN", 64'(ramREN), 64'(e_ren));
    check_eq("ramWEN", 64'(ramWEN), 64'(e_wen));
    check_eq("ramaddr", 64'(ramaddr), 64'(e_addr));
    check_eq("ramstore", 64'(ramstore), 64'(e_store));
    check_eq("timeout", 64'(timeout), 64'(m_to));
    // Completion rewrites the expected wait/load of the granted channel before comparing.
    if (m_busy && ramstate == 2'd2) begin
      if (m_data) begin e_dwait[m_core] = 0; e_dload[m_core] = ramload; end
      else        begin e_iwait[m_core] = 0; e_iload[m_core] = ramload; end
    end
    check_eq("iwait", 64'(iwait), 64'(e_iwait));
    check_eq("dwait", 64'(dwait), 64'(e_dwait));
    check_eq("iload", 64'(iload), 64'(e_iload));
    check_eq("dload", 64'(dload), 64'(e_dload));
    if (nRST) begin
      if (m_busy) begin
        m_busy = 0;
        if (ramstate == 2'd2) m_prio = !m_core;
        else if (!still) ;
        else if (ramstate == 2'd3) m_prio = !m_core;
        else if (m_waited == int'(TO) - 1) begin m_prio = !m_core; nxt_to[m_core] = 1; end
        else begin m_busy = 1; m_waited++; end
      end else if ((iREN | dREN | dWEN) != 2'b00) begin
        pick = ((iREN[m_prio] | dREN[m_prio] | dWEN[m_prio]) != 0) ? m_prio : !m_prio;
        m_busy = 1; m_core = pick; m_data = dREN[pick] | dWEN[pick]; m_waited = 0;
      end
      m_to = nxt_to;
    end
  endtask

  task automatic step();
    settle();
    @(negedge CLK);
  endtask

  task automatic randomize_inputs();
    int r;
    for (int c = 0; c < 2; c++) begin
      if ($urandom_range(7) == 0) iREN[c] = ~iREN[c];
      if ($urandom_range(9) == 0) dREN[c] = ~dREN[c];
      if ($urandom_range(9) == 0) dWEN[c] = ~dWEN[c];
      if ($urandom_range(15) == 0) iaddr[c] = $urandom();
      if ($urandom_range(15) == 0) daddr[c] = $urandom();
      if ($urandom_range(15) == 0) dstore[c] = $urandom();
    end
    ramload = $urandom();
    r = int'($urandom_range(9));
    ramstate = (r < 5) ? 2'd2 : (r < 8) ? 2'd1 : (r == 8) ? 2'd0 : 2'd3;
  endtask

  initial begin
    nRST = 0; iREN = 0; dREN = 0; dWEN = 0; iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = 2'd0;
    m_busy = 0; m_prio = 0; m_to = 0; m_core = 0; m_data = 0; m_waited = 0;
    @(negedge CLK);
    step(); step();
    nRST = 1;
    step();

    // Core0 fetch completing after two BUSY cycles.
    iREN = 2'b01; iaddr[0] = 32'h40; ramstate = 2'd1;
    step();
    for (int k = 0; k < 2; k++) begin
      settle();
      check_eq("tp1_ren", 64'(ramREN), 64'd1);
      check_eq("tp1_addr", 64'(ramaddr), 64'h40);
      @(negedge CLK);
    end
    ramstate = 2'd2; ramload = 32'h8C010004;
    settle();
    check_eq("tp1_iwait0", 64'(iwait[0]), 64'd0);
    check_eq("tp1_iload0", 64'(iload[0]), 64'h8C010004);
    @(negedge CLK);
    iREN = 2'b00;
    step();

    // Core1 write beats its own fetch; core0 fetch comes before core1 fetch.
    iREN = 2'b11; dWEN = 2'b10; daddr[1] = 32'h100; dstore[1] = 32'hDEADBEEF; iaddr[1] = 32'h80;
    step();
    settle();
    check_eq("tp2_wen", 64'(ramWEN), 64'd1);
    check_eq("tp2_store", 64'(ramstore), 64'hDEADBEEF);
    check_eq("tp2_addr", 64'(ramaddr), 64'h100);
    @(negedge CLK);
    dWEN = 2'b00;
    step();
    settle();
    check_eq("tp2_core0_fetch", 64'(ramaddr), 64'h40);
    @(negedge CLK);
    iREN = 2'b10;
    step();
    settle();
    check_eq("tp2_core1_fetch", 64'(ramaddr), 64'h80);
    @(negedge CLK);
    iREN = 2'b00;
    step();

    // Read and write together on core0: the write wins.
    dREN = 2'b01; dWEN = 2'b01; daddr[0] = 32'h200;
    step();
    settle();
    check_eq("tp4_wen", 64'(ramWEN), 64'd1);
    check_eq("tp4_ren", 64'(ramREN), 64'd0);
    @(negedge CLK);
    dREN = 2'b00; dWEN = 2'b00;
    step();

    // RAM stuck BUSY on a core1 write: abort after TO grant cycles, then core0 is served.
    dWEN = 2'b10; daddr[1] = 32'h300; iREN = 2'b01; ramstate = 2'd1;
    step();
    for (int k = 0; k < int'(TO); k++) step();
    settle();
    check_eq("tp5_timeout", 64'(timeout), 64'b10);
    check_eq("tp5_dwait1", 64'(dwait[1]), 64'd1);
    check_eq("tp5_idle_wen", 64'(ramWEN), 64'd0);
    @(negedge CLK);
    settle();
    check_eq("tp5_next_core0", 64'(ramaddr), 64'h40);
    @(negedge CLK);
    iREN = 2'b00; dWEN = 2'b00;
    step(); step();

    // Reset in the middle of a grant.
    iREN = 2'b11;
    step();
    step();
    nRST = 0;
    settle();
    check_eq("tp6_rst_ren", 64'(ramREN), 64'd0);
    @(negedge CLK);
    nRST = 1;
    step();
    settle();
    check_eq("tp6_core0_wins", 64'(ramaddr), 64'h40);
    @(negedge CLK);

    // Random traffic with a reset pulse partway through.
    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      nRST = (n == 1500 || n == 1501) ? 1'b0 : 1'b1;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
